perf_counter_bank: RTL

Parametrised hardware performance-counter bank for the pipelined processor. It counts cycles, retired instructions and NUM_CH event channels, such as taken branches, stalls and flushes. It snapshots all counters atomically into shadow registers and serves single-counter reads with fixed one-cycle latency. It sits beside the pipeline, fed by single-cycle event pulses from the execute/write-back stages, and replaces ad-hoc waveform probing of PC/branch activity with counters readable in simulation or by a debug port.

---
 rtl/perf_counter_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: free-running cycle, retired-instruction and NUM_CH event
// counters with sticky overflow flags, an atomic snapshot into shadow
// registers and a one-cycle-latency single-counter read port.
module perf_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0,
    localparam int SEL_W   = $clog2(NUM_CH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              count_en,
    input  logic              freeze,
    input  logic              clear,
    input  logic              retire,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              snap,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              rd_err,
    output logic              ovf_any
);

    // Index 0 is the cycle counter, 1 the retired counter, 2+k event channel k.
    localparam int NCNT = NUM_CH + 2;

    logic [CNT_W-1:0] live     [NCNT];
    logic [CNT_W-1:0] live_nxt [NCNT];
    logic [CNT_W-1:0] shadow   [NCNT];
    logic [NCNT-1:0]  sticky;
    logic [NCNT-1:0]  sticky_nxt;
    logic [NCNT-1:0]  src;
    logic [CNT_W-1:0] sel_data;
    logic             sel_ovf;
    logic             sel_hit;

    assign src = {event_in, retire, 1'b1};

    // Next state of live counters and sticky bits; clear wins over freeze, which wins over count_en.
    always_comb begin
        sticky_nxt = sticky;
        for (int i = 0; i < NCNT; i++) begin
            live_nxt[i] = live[i];
        end
        if (clear) begin
            sticky_nxt = '0;
            for (int i = 0; i < NCNT; i++) begin
                live_nxt[i] = '0;
            end
        end else if (!freeze && count_en) begin
            for (int i = 0; i < NCNT; i++) begin
                if (src[i]) begin
                    if (live[i] == {CNT_W{1'b1}}) begin
                        sticky_nxt[i] = 1'b1;
                        live_nxt[i]   = SATURATE ? live[i] : '0;
                    end else begin
                        live_nxt[i] = live[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read-port mux: rd_sel is compared against each valid index, so an out-of-range select simply misses.
    always_comb begin
        sel_hit  = 1'b0;
        sel_data = '0;
        sel_ovf  = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                sel_data = shadow[i];
                sel_ovf  = sticky_nxt[i];
            end
        end
    end

    // All state: counters, shadows (pre-edge live values on snap), sticky summary and the registered read response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            sticky   <= '0;
            ovf_any  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            live    <= live_nxt;
            sticky  <= sticky_nxt;
            ovf_any <= |sticky_nxt;
            if (snap) begin
                shadow <= live;
            end
            if (rd_req) begin
                rd_valid <= 1'b1;
                rd_data  <= sel_hit ? sel_data : '0;
                rd_ovf   <= sel_hit ? sel_ovf : 1'b0;
                rd_err   <= !sel_hit;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
